rd_stream: RTL and testbench

Parametrised, handshaked successor to the combinational radial-difference (RD) comparator in the MRELBP feature path. Each transaction takes P inner-ring and P outer-ring sample points in Q16.8 form and produces one P-bit RD code. Each code bit is set when the outer point exceeds the inner point by more than a programmable threshold. A per-transaction mode selects the raw code, the rotation-invariant code (minimum over circular rotations) or the riu2 uniform code. The block sits between the interpolation stage and the histogram accumulator.

---
 rtl/rd_stream.sv | 115 +++++++++++
 tb/tb_rd_stream.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_stream.sv
// Handshaked radial-difference coder: raw, rotation-invariant
// or riu2 code from P inner/outer ring points.
module rd_stream #(
  parameter int FIXED = 24,
  parameter int P     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P*FIXED-1:0] i_inner,
  input  logic [P*FIXED-1:0] i_outer,
  input  logic [FIXED-1:0]   i_thresh,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P-1:0]       o_code
);

  localparam int NW = $clog2(P);
  localparam int CW = $clog2(P + 2);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    ROT,
    OUT
  } state_t;

  state_t        state;
  logic [1:0]    mode_q;
  logic [P-1:0]  bits;
  logic [P-1:0]  cur;
  logic [P-1:0]  best;
  logic [NW-1:0] cnt;

  logic [P-1:0]  cmp;
  logic [P-1:0]  rot;
  logic [P-1:0]  rmin;
  logic [P-1:0]  riu2;
  logic [CW-1:0] ones;
  logic [CW-1:0] trans;

  // Sum kept one bit wider so inner + thresh never wraps.
  for (genvar g = 0; g < P; g++) begin : g_cmp
    logic [FIXED:0] lim;
    assign lim = {1'b0, i_inner[g*FIXED +: FIXED]}
               + {1'b0, i_thresh};
    assign cmp[g] = {1'b0, i_outer[g*FIXED +: FIXED]} > lim;
  end

  assign rot  = {cur[0], cur[P-1:1]};
  assign rmin = (rot < best) ? rot : best;

  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < P; i++) begin
      ones  = ones + CW'(bits[i]);
      trans = trans + CW'(bits[i] ^ bits[(i + 1) % P]);
    end
    riu2 = (trans <= CW'(2)) ? P'(ones) : P'(P + 1);
  end

  assign o_ready = (state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      mode_q  <= '0;
      bits    <= '0;
      cur     <= '0;
      best    <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_code  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            bits   <= cmp;
            cur    <= cmp;
            best   <= cmp;
            cnt    <= '0;
            mode_q <= i_mode;
            state  <= (i_mode == 2'd1) ? ROT : EVAL;
          end
        end
        EVAL: begin
          o_code  <= (mode_q == 2'd2) ? riu2 : bits;
          o_valid <= 1'b1;
          state   <= OUT;
        end
        ROT: begin
          cur  <= rot;
          best <= rmin;
          cnt  <= cnt + NW'(1);
          if (cnt == NW'(P - 2)) begin
            o_code  <= rmin;
            o_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_stream.sv
// Directed bench for rd_stream with a scoreboard fed by a
// spec-level model of the RD code rules.
module tb_rd_stream;

  localparam int FIXED = 24;
  localparam int P     = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  logic [P*FIXED-1:0] i_inner;
  logic [P*FIXED-1:0] i_outer;
  logic [FIXED-1:0]   i_thresh;
  logic [1:0]         i_mode;
  logic               o_valid;
  logic               i_ready;
  logic [P-1:0]       o_code;

  rd_stream #(.FIXED(FIXED), .P(P)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_inner (i_inner),
    .i_outer (i_outer),
    .i_thresh(i_thresh),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_code  (o_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [FIXED-1:0] inn [P];
  logic [FIXED-1:0] outr[P];
  logic [FIXED-1:0] th;
  logic [P-1:0]     expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [P-1:0] model_bits();
    logic [P-1:0] b;
    for (int i = 0; i < P; i++)
      b[i] = longint'(outr[i]) > longint'(inn[i]) + longint'(th);
    return b;
  endfunction

  function automatic logic [P-1:0] model_code(input logic [P-1:0] b,
                                              input logic [1:0] m);
    logic [P-1:0] r, best;
    int t;
    if (m == 2'd1) begin
      best = '1;
      for (int k = 0; k < P; k++) begin
        r = (b >> k) | (b << (P - k));
        if (r < best) best = r;
      end
      return best;
    end
    if (m == 2'd2) begin
      t = 0;
      for (int i = 0; i < P; i++)
        if (b[i] != b[(i + 1) % P]) t++;
      return (t <= 2) ? P'($countones(b)) : P'(P + 1);
    end
    return b;
  endfunction

  // Pattern helper: equal points give 0, outer one pixel up gives 1.
  task automatic mk(input logic [P-1:0] pat);
    th = '0;
    for (int i = 0; i < P; i++) begin
      inn[i]  = 24'h000800;
      outr[i] = pat[i] ? 24'h000900 : 24'h000800;
    end
  endtask

  // Scoreboard: every cycle a result is presented it must match.
  always @(negedge clk) begin
    if (o_valid) begin
      if (expq.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("scoreboard", 32'(o_code), 32'(expq[0]));
    end
  end

  always @(posedge clk)
    if (rst_n && o_valid && i_ready && expq.size() > 0)
      void'(expq.pop_front());

  task automatic send(input string nm, input logic [1:0] mode,
                      input int stall, input bit pulse,
                      input logic [P-1:0] hand);
    int lat, guard;
    logic [P-1:0] e;
    for (int i = 0; i < P; i++) begin
      i_inner[i*FIXED +: FIXED] = inn[i];
      i_outer[i*FIXED +: FIXED] = outr[i];
    end
    i_thresh = th;
    i_mode   = mode;
    e = model_code(model_bits(), mode);
    chk({nm, "_model"}, 32'(e), 32'(hand));
    i_ready = (stall == 0);
    i_valid = 1'b1;
    guard = 0;
    while (!o_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk({nm, "_accept_timeout"}, 0, 1);
    expq.push_back(e);
    @(posedge clk); #1;
    acc_cyc = cyc;
    i_valid = 1'b0;
    lat = (mode == 2'd1) ? P - 1 : 1;
    for (int k = 1; k <= lat; k++) begin
      chk({nm, "_early_valid"}, 32'(o_valid), 0);
      chk({nm, "_busy"}, 32'(o_ready), 0);
      if (pulse) begin
        i_valid = 1'b1;
        i_mode  = 2'd0;
        i_inner = '0;
        i_outer = '1;
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
    chk({nm, "_valid"}, 32'(o_valid), 1);
    chk({nm, "_code"}, 32'(o_code), 32'(hand));
    chk({nm, "_busy_out"}, 32'(o_ready), 0);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
        chk({nm, "_hold_valid"}, 32'(o_valid), 1);
        chk({nm, "_hold_code"}, 32'(o_code), 32'(hand));
        chk({nm, "_hold_busy"}, 32'(o_ready), 0);
      end
      i_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_drop_valid"}, 32'(o_valid), 0);
    chk({nm, "_idle"}, 32'(o_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_inner  = '0;
    i_outer  = '0;
    i_thresh = '0;
    i_mode   = '0;
    mk('0);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_code", 32'(o_code), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    mk(8'h55);
    send("raw55", 2'd0, 0, 0, 8'h55);

    th = 24'h000080;
    for (int i = 0; i < P; i++) begin
      inn[i]  = 24'(i * 24'h001000 + 24'h34);
      outr[i] = inn[i] + 24'h80;
    end
    send("thr_eq", 2'd0, 0, 0, 8'h00);
    th = 24'h00007F;
    send("thr_lo", 2'd0, 0, 0, 8'hFF);

    th = 24'h000001;
    for (int i = 0; i < P; i++) begin
      inn[i]  = 24'hFFFFFF;
      outr[i] = 24'hFFFFFF;
    end
    send("nowrap", 2'd0, 0, 0, 8'h00);
    th = 24'h000000;
    outr[3] = 24'hFFFFFF;
    inn[3]  = 24'hFFFFFE;
    send("top_edge", 2'd0, 0, 0, 8'h08);

    mk(8'hB0);
    send("rot_b0", 2'd1, 0, 1, 8'h0B);
    a0 = acc_cyc;
    mk(8'h80);
    send("rot_80", 2'd1, 0, 0, 8'h01);
    chk("rot_spacing", 32'(acc_cyc - a0), 32'(P + 1));

    mk(8'h1C);
    send("riu_1c", 2'd2, 0, 0, 8'd3);
    mk(8'h55);
    send("riu_55", 2'd2, 0, 1, 8'd9);
    mk(8'h00);
    send("riu_00", 2'd2, 0, 0, 8'd0);
    mk(8'hFF);
    send("riu_ff", 2'd2, 0, 0, 8'd8);
    mk(8'h1C);
    send("mode3", 2'd3, 0, 0, 8'h1C);

    mk(8'h3A);
    send("bp", 2'd0, 5, 0, 8'h3A);
    mk(8'hC3);
    send("b2b_a", 2'd0, 0, 0, 8'hC3);
    a0 = acc_cyc;
    mk(8'h0F);
    send("b2b_b", 2'd0, 0, 0, 8'h0F);
    chk("b2b_spacing", 32'(acc_cyc - a0), 3);

    // Abort a rotation pass midway.
    mk(8'hB0);
    i_mode  = 2'd1;
    i_ready = 1'b1;
    for (int i = 0; i < P; i++) begin
      i_inner[i*FIXED +: FIXED] = inn[i];
      i_outer[i*FIXED +: FIXED] = outr[i];
    end
    i_thresh = th;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rot_busy", 32'(o_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_code", 32'(o_code), 0);
    chk("abort_ready", 32'(o_ready), 1);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(o_ready), 1);
    chk("post_rst_valid", 32'(o_valid), 0);
    mk(8'h96);
    send("post_rst_raw", 2'd0, 0, 0, 8'h96);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
